// File: rtl/axi_lite_wr_ctrl_pkg.sv
// Shared types and constants for the AXI-Lite write controller.
// Holds the write FSM state encoding and the AXI write-response codes.
package axi_lite_wr_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WAIT_W = 3'd1,
    WAIT_A = 3'd2,
    WRITE  = 3'd3,
    RESP   = 3'd4
  } wr_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/axi_lite_wr_ctrl.sv
// AXI-Lite write-channel controller driving a simple register-file write port.
// Accepts AW and W in either order (or together), issues one reg_we pulse,
// then returns a single B response before accepting the next transaction.
// Optional feature: define AXI_WR_ADDR_ERR_EN to reject word indices
// >= NUM_REGS with SLVERR and no register write; otherwise the index is
// truncated and the response is OKAY.
module axi_lite_wr_ctrl
  import axi_lite_wr_ctrl_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 16
) (
  input  logic                        s_axi_aclk,
  input  logic                        s_axi_aresetn,
  input  logic                        s_axi_awvalid,
  output logic                        s_axi_awready,
  input  logic [ADDR_W-1:0]           s_axi_awaddr,
  input  logic                        s_axi_wvalid,
  output logic                        s_axi_wready,
  input  logic [DATA_W-1:0]           s_axi_wdata,
  input  logic [DATA_W/8-1:0]         s_axi_wstrb,
  output logic                        s_axi_bvalid,
  input  logic                        s_axi_bready,
  output logic [1:0]                  s_axi_bresp,
  output logic                        reg_we,
  output logic [$clog2(NUM_REGS)-1:0] reg_idx,
  output logic [DATA_W-1:0]           reg_wdata,
  output logic [DATA_W/8-1:0]         reg_wstrb,
  output logic                        aw_done,
  output logic                        w_done
);

  localparam int STRB_W = DATA_W / 8;
  localparam int OFF_W  = $clog2(STRB_W);
  localparam int IDX_W  = $clog2(NUM_REGS);
  localparam int WORD_W = ADDR_W - OFF_W;

  wr_state_e          state_q, state_d;
  logic               awready_q, awready_d;
  logic               wready_q, wready_d;
  logic [IDX_W-1:0]   reg_idx_q, reg_idx_d;
  logic [DATA_W-1:0]  reg_wdata_q, reg_wdata_d;
  logic [STRB_W-1:0]  reg_wstrb_q, reg_wstrb_d;
  logic               aw_done_q, aw_done_d;
  logic               w_done_q, w_done_d;
  logic               addr_err_q, addr_err_d;

  logic               aw_hs;
  logic               w_hs;
  logic [WORD_W-1:0]  word_idx;
  logic               word_oor;
  logic               unused_addr_bits;

  // Handshakes use the registered readies so nothing is accepted during or
  // in the very cycle of reset release.
  assign aw_hs    = s_axi_awvalid & awready_q;
  assign w_hs     = s_axi_wvalid & wready_q;
  assign word_idx = s_axi_awaddr[ADDR_W-1:OFF_W];

  // Byte-offset bits and index bits above the register range carry no meaning here.
  assign unused_addr_bits = ^{s_axi_awaddr[OFF_W-1:0], word_idx};

`ifdef AXI_WR_ADDR_ERR_EN
  assign word_oor = (32'(word_idx) >= 32'(NUM_REGS));
`else
  assign word_oor = 1'b0;
`endif

  // State and registered-ready flops; everything clears asynchronously on reset.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      state_q   <= IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
    end
  end

  // Next-state logic and output decode for the write FSM.
  always_comb begin
    state_d       = state_q;
    reg_we        = 1'b0;
    s_axi_bvalid  = 1'b0;
    s_axi_bresp   = RESP_OKAY;
    unique case (state_q)
      IDLE: begin
        if (aw_hs && w_hs)   state_d = WRITE;
        else if (aw_hs)      state_d = WAIT_W;
        else if (w_hs)       state_d = WAIT_A;
      end
      WAIT_W: if (w_hs)  state_d = WRITE;
      WAIT_A: if (aw_hs) state_d = WRITE;
      WRITE: begin
        reg_we  = ~addr_err_q;
        state_d = RESP;
      end
      RESP: begin
        s_axi_bvalid = 1'b1;
        s_axi_bresp  = addr_err_q ? RESP_SLVERR : RESP_OKAY;
        if (s_axi_bready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Readies are registered from the next state so they are 0 in WRITE/RESP
    // and reopen only the cycle after the B handshake.
    awready_d = (state_d == IDLE) || (state_d == WAIT_A);
    wready_d  = (state_d == IDLE) || (state_d == WAIT_W);
  end

  // Capture each channel on its own handshake; done flags drop once the write fires.
  always_comb begin
    reg_idx_d   = reg_idx_q;
    reg_wdata_d = reg_wdata_q;
    reg_wstrb_d = reg_wstrb_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    addr_err_d  = addr_err_q;
    if (aw_hs) begin
      reg_idx_d  = word_idx[IDX_W-1:0];
      addr_err_d = word_oor;
      aw_done_d  = 1'b1;
    end
    if (w_hs) begin
      reg_wdata_d = s_axi_wdata;
      reg_wstrb_d = s_axi_wstrb;
      w_done_d    = 1'b1;
    end
    if (state_d == WRITE) begin
      aw_done_d = 1'b0;
      w_done_d  = 1'b0;
    end
  end

  // Captured address/data registers feeding the register-file port.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      reg_idx_q   <= '0;
      reg_wdata_q <= '0;
      reg_wstrb_q <= '0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      addr_err_q  <= 1'b0;
    end else begin
      reg_idx_q   <= reg_idx_d;
      reg_wdata_q <= reg_wdata_d;
      reg_wstrb_q <= reg_wstrb_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      addr_err_q  <= addr_err_d;
    end
  end

  assign s_axi_awready = awready_q;
  assign s_axi_wready  = wready_q;
  assign reg_idx       = reg_idx_q;
  assign reg_wdata     = reg_wdata_q;
  assign reg_wstrb     = reg_wstrb_q;
  assign aw_done       = aw_done_q;
  assign w_done        = w_done_q;

endmodule
